// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Optional access timeout with sticky err is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

    state_t        state_q;
    logic [DW-1:0] if_rdata_q, d_rdata_q, m_wdata_q;
    logic [AW-1:0] m_addr_q;
    logic          if_valid_q, d_valid_q, m_en_q, m_we_q;
    logic          d_req, expired;

    assign d_req = mem_read | mem_write;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;
    // The entry cycle counts as access cycle one, so abort fires after TIMEOUT cycles.
    assign expired = (cnt_q == CW'(TIMEOUT - 1));
    assign err     = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign expired        = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A requester whose valid is high this cycle is still showing the finished access.
                    if (d_req && !d_valid_q) begin
                        state_q   <= D_ACC;
                        m_en_q    <= 1'b1;
                        m_we_q    <= mem_write;
                        m_addr_q  <= d_addr;
                        m_wdata_q <= d_wdata;
`ifdef ARB_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end else if (if_req && !if_valid_q) begin
                        state_q  <= I_ACC;
                        m_en_q   <= 1'b1;
                        m_we_q   <= 1'b0;
                        m_addr_q <= if_addr;
`ifdef ARB_TIMEOUT_EN
                        cnt_q    <= '0;
`endif
                    end
                end
                I_ACC, D_ACC: begin
                    if (m_ready || expired) begin
                        state_q <= IDLE;
                        m_en_q  <= 1'b0;
                        m_we_q  <= 1'b0;
                        if (state_q == I_ACC) begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= m_ready ? m_rdata : '0;
                        end else begin
                            d_valid_q <= 1'b1;
                            if (!m_ready)
                                d_rdata_q <= '0;
                            else if (!m_we_q)
                                d_rdata_q <= m_rdata;
                        end
`ifdef ARB_TIMEOUT_EN
                        if (!m_ready)
                            err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign m_en      = m_en_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (timeout scenario runs when ARB_TIMEOUT_EN is defined).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        mem_read, mem_write;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_valid, stall_if, stall_mem;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_ready, err;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_read(mem_read), .mem_write(mem_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .stall_if(stall_if), .stall_mem(stall_mem),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
    );

    // Advance to just after the next rising edge; inputs are driven here, checks follow a settle delay.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b1; mem_read = 1'b1; mem_write = 1'b1; m_ready = 1'b1;
        if_addr = 32'h10; d_addr = 32'h20; d_wdata = 32'h30; m_rdata = 32'hFFFF_FFFF;
        step(); step();
        #1;
        vecs++; if ({m_en, m_we, if_valid, d_valid, err} !== 5'b0) begin
            errs++; $display("FAIL reset_ctrl got=%b exp=00000", {m_en, m_we, if_valid, d_valid, err}); end
        vecs++; if ({if_rdata, d_rdata, m_addr, m_wdata} !== 128'h0) begin
            errs++; $display("FAIL reset_data got=%h exp=0", {if_rdata, d_rdata, m_addr, m_wdata}); end
        reset = 1'b0; if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0; m_ready = 1'b0;
        step(); #1;
        vecs++; if (m_en !== 1'b0 || if_valid !== 1'b0 || d_valid !== 1'b0) begin
            errs++; $display("FAIL reset_idle got=%b exp=000", {m_en, if_valid, d_valid}); end
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h40; m_ready = 1'b1; m_rdata = 32'h8C22_0004;
        #1;
        vecs++; if (stall_if !== 1'b1 || m_en !== 1'b0) begin
            errs++; $display("FAIL fetch_c0 got stall_if=%b m_en=%b exp 1 0", stall_if, m_en); end
        step(); #1;
        vecs++; if ({m_en, m_we, stall_if, if_valid} !== 4'b1010 || m_addr !== 32'h40) begin
            errs++; $display("FAIL fetch_c1 got en/we/stall/valid=%b addr=%h exp 1010 40",
                             {m_en, m_we, stall_if, if_valid}, m_addr); end
        step(); #1;
        vecs++; if ({if_valid, stall_if, m_en} !== 3'b100 || if_rdata !== 32'h8C22_0004) begin
            errs++; $display("FAIL fetch_c2 got valid/stall/en=%b rdata=%h exp 100 8c220004",
                             {if_valid, stall_if, m_en}, if_rdata); end
        if_req = 1'b0;
        step(); #1;
        vecs++; if (if_valid !== 1'b0 || m_en !== 1'b0 || if_rdata !== 32'h8C22_0004) begin
            errs++; $display("FAIL fetch_c3 got valid=%b en=%b rdata=%h exp 0 0 8c220004",
                             if_valid, m_en, if_rdata); end
    endtask

    task automatic test_priority();
        if_req = 1'b1; if_addr = 32'h44; mem_read = 1'b1; d_addr = 32'h100;
        m_ready = 1'b1; m_rdata = 32'h1111_1111;
        step(); #1;
        vecs++; if (m_en !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h100 || {stall_if, stall_mem} !== 2'b11) begin
            errs++; $display("FAIL prio_c1 got en=%b we=%b addr=%h stalls=%b exp 1 0 100 11",
                             m_en, m_we, m_addr, {stall_if, stall_mem}); end
        step(); #1;
        vecs++; if ({d_valid, stall_mem, stall_if, m_en} !== 4'b1010 || d_rdata !== 32'h1111_1111) begin
            errs++; $display("FAIL prio_c2 got dv/smem/sif/en=%b d_rdata=%h exp 1010 11111111",
                             {d_valid, stall_mem, stall_if, m_en}, d_rdata); end
        mem_read = 1'b0; m_rdata = 32'h2222_2222;
        step(); #1;
        vecs++; if (m_en !== 1'b1 || m_addr !== 32'h44 || d_valid !== 1'b0 || stall_if !== 1'b1) begin
            errs++; $display("FAIL prio_c3 got en=%b addr=%h dv=%b sif=%b exp 1 44 0 1",
                             m_en, m_addr, d_valid, stall_if); end
        step(); #1;
        vecs++; if (if_valid !== 1'b1 || if_rdata !== 32'h2222_2222 || stall_if !== 1'b0 || d_rdata !== 32'h1111_1111) begin
            errs++; $display("FAIL prio_c4 got iv=%b if_rdata=%h sif=%b d_rdata=%h exp 1 22222222 0 11111111",
                             if_valid, if_rdata, stall_if, d_rdata); end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_write_wait();
        mem_write = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; m_ready = 1'b0; m_rdata = 32'hBAD0_BAD0;
        #1;
        vecs++; if (stall_mem !== 1'b1) begin
            errs++; $display("FAIL wr_stall_c0 got=%b exp=1", stall_mem); end
        for (int c = 1; c <= 4; c++) begin
            step();
            d_addr = 32'h999; d_wdata = 32'h0;
            if (c == 4) m_ready = 1'b1;
            #1;
            vecs++; if ({m_en, m_we, stall_mem, d_valid} !== 4'b1110 || m_addr !== 32'h200 || m_wdata !== 32'hDEAD_BEEF) begin
                errs++; $display("FAIL wr_hold c%0d got en/we/smem/dv=%b addr=%h wdata=%h exp 1110 200 deadbeef",
                                 c, {m_en, m_we, stall_mem, d_valid}, m_addr, m_wdata); end
        end
        step(); #1;
        vecs++; if ({d_valid, stall_mem, m_en, m_we} !== 4'b1000 || d_rdata !== 32'h1111_1111) begin
            errs++; $display("FAIL wr_done got dv/smem/en/we=%b d_rdata=%h exp 1000 11111111",
                             {d_valid, stall_mem, m_en, m_we}, d_rdata); end
        mem_write = 1'b0; m_ready = 1'b0;
        step(); #1;
        vecs++; if (d_valid !== 1'b0 || m_en !== 1'b0) begin
            errs++; $display("FAIL wr_after got dv=%b en=%b exp 0 0", d_valid, m_en); end
    endtask

    task automatic test_back_to_back();
        // Expected per cycle 1..8 : m_en, m_addr (when enabled), d_valid, if_valid
        logic [7:0]  exp_en = 8'b0101_0101;  // bit i-1 is cycle i
        logic [7:0]  exp_dv = 8'b0010_0010;
        logic [7:0]  exp_iv = 8'b1000_1000;
        logic [31:0] exp_addr [1:8] = '{32'h300, 32'h0, 32'h80, 32'h0, 32'h300, 32'h0, 32'h80, 32'h0};
        if_req = 1'b1; if_addr = 32'h80; mem_read = 1'b1; d_addr = 32'h300;
        m_ready = 1'b1; m_rdata = 32'h5A5A_5A5A;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 8) begin if_req = 1'b0; mem_read = 1'b0; end
            #1;
            vecs++; if ({m_en, d_valid, if_valid} !== {exp_en[c-1], exp_dv[c-1], exp_iv[c-1]} ||
                        (exp_en[c-1] && m_addr !== exp_addr[c])) begin
                errs++; $display("FAIL b2b c%0d got en/dv/iv=%b addr=%h exp %b addr=%h", c,
                                 {m_en, d_valid, if_valid},
                                 m_addr, {exp_en[c-1], exp_dv[c-1], exp_iv[c-1]}, exp_addr[c]); end
        end
        step(); #1;
        vecs++; if (m_en !== 1'b0 || if_rdata !== 32'h5A5A_5A5A || d_rdata !== 32'h5A5A_5A5A) begin
            errs++; $display("FAIL b2b_end got en=%b if_rdata=%h d_rdata=%h exp 0 5a5a5a5a 5a5a5a5a",
                             m_en, if_rdata, d_rdata); end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        if_req = 1'b1; if_addr = 32'h500; m_ready = 1'b0; m_rdata = 32'hFFFF_FFFF;
        for (int c = 1; c <= 16; c++) begin
            step(); #1;
            vecs++; if (m_en !== 1'b1 || if_valid !== 1'b0 || err !== 1'b0) begin
                errs++; $display("FAIL tmo_wait c%0d got en=%b iv=%b err=%b exp 1 0 0", c, m_en, if_valid, err); end
        end
        step();
        if_req = 1'b0;
        #1;
        vecs++; if (if_valid !== 1'b1 || if_rdata !== 32'h0 || err !== 1'b1 || m_en !== 1'b0) begin
            errs++; $display("FAIL tmo_abort got iv=%b rdata=%h err=%b en=%b exp 1 0 1 0",
                             if_valid, if_rdata, err, m_en); end
        step(); step(); #1;
        vecs++; if (err !== 1'b1 || if_valid !== 1'b0) begin
            errs++; $display("FAIL tmo_sticky got err=%b iv=%b exp 1 0", err, if_valid); end
    endtask
`endif

    task automatic test_reset_mid_access();
        mem_read = 1'b1; d_addr = 32'h400; m_ready = 1'b0; m_rdata = 32'h7777_7777;
        step(); #1;
        vecs++; if (m_en !== 1'b1 || m_addr !== 32'h400) begin
            errs++; $display("FAIL rst_mid_c1 got en=%b addr=%h exp 1 400", m_en, m_addr); end
        step();
        reset = 1'b1; m_ready = 1'b1;
        step();
        reset = 1'b0; mem_read = 1'b0; m_ready = 1'b0;
        #1;
        vecs++; if ({m_en, d_valid, err} !== 3'b000 || d_rdata !== 32'h0) begin
            errs++; $display("FAIL rst_mid_c3 got en/dv/err=%b d_rdata=%h exp 000 0", {m_en, d_valid, err}, d_rdata); end
        step(); #1;
        vecs++; if (m_en !== 1'b0 || d_valid !== 1'b0) begin
            errs++; $display("FAIL rst_mid_c4 got en=%b dv=%b exp 0 0", m_en, d_valid); end
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0; m_ready = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        test_reset();
        test_fetch();
        test_priority();
        test_write_wait();
        test_back_to_back();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: instruction fetch (IF stage) and data access (MEM stage, driven by the MemRead/MemWrite decode outputs).
- Sequences each access through a small FSM, holds the memory interface stable across wait states, and generates the stall signals that freeze the pipeline while a requester is waiting.
- Sits between the pipeline stages and the memory model/controller.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max cycles in an access state before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
if_req  input  1  fetch request, held until if_valid
if_addr  input  AW  fetch address
if_rdata  output  DW  fetched word, valid with if_valid
if_valid  output  1  one-cycle fetch completion pulse
mem_read  input  1  data read request
mem_write  input  1  data write request (never asserted with mem_read)
d_addr  input  AW  data address
d_wdata  input  DW  write data
d_rdata  output  DW  load data, valid with d_valid
d_valid  output  1  one-cycle data completion pulse (reads and writes)
stall_if  output  1  if_req & ~if_valid
stall_mem  output  1  (mem_read | mem_write) & ~d_valid
m_en  output  1  memory access active
m_we  output  1  write strobe, valid while m_en
m_addr  output  AW  memory address
m_wdata  output  DW  memory write data
m_rdata  input  DW  memory read data, sampled when m_ready
m_ready  input  1  access complete this cycle (may be high in first m_en cycle)
err  output  1  sticky timeout flag (ARB_TIMEOUT_EN only; else tied 0)

Behaviour:
- States: IDLE, I_ACC, D_ACC. Reset -> IDLE; all registered outputs (if_rdata, d_rdata, if_valid, d_valid, m_en, m_we, m_addr, m_wdata, err) = 0.
- IDLE: data request (mem_read|mem_write) has priority -> D_ACC; else if_req -> I_ACC; else stay.
- On grant: latch address (and d_wdata, write flag) into registers driving m_addr/m_wdata/m_we; m_en=1 from the next cycle. Interface stable for the whole access state regardless of input changes.
- I_ACC/D_ACC: wait for m_ready. On m_ready: deassert m_en/m_we next edge, go to IDLE, pulse matching *_valid for exactly one cycle; reads register m_rdata into if_rdata/d_rdata; d_rdata unchanged on writes.
- Rdata registers hold value until the next completion of the same requester.
- Minimum latency: request seen in IDLE at cycle N, m_en at N+1, valid at N+2 (zero wait states). Each wait cycle adds one.
- Completion mask: in the cycle a requester's *_valid is high, that requester's request is ignored by the IDLE arbiter (the pipeline is advancing; its request still reflects the completed access). Consequence: after a data access, a pending fetch always wins the next slot, so fetch is never starved.
- stall_if/stall_mem are combinational from inputs and registered valids; they deassert exactly in the valid cycle.
- m_ready outside access states ignored.
- Reset mid-access: next edge forces IDLE, m_en=0, no valid pulse; the access is abandoned.
- mem_read & mem_write both high: treated as write (illegal; decode never produces it).

Optional Feature:
ARB_TIMEOUT_EN: defined -> cycle counter (width ceil(log2(TIMEOUT+1))) cleared on entering an access state, increments each cycle without m_ready; reaching TIMEOUT aborts: IDLE, valid pulse with rdata = 0, err set (sticky until reset). Undefined -> no counter, waits indefinitely, err tied 0.

Test Plan:
- Reset with all inputs active -> cycle after reset: m_en=0, if_valid=d_valid=0, rdata=0, err=0; state IDLE.
- if_req=1, if_addr=0x40, m_ready=1, m_rdata=0x8C220004 -> m_en/m_addr=0x40 at cycle 1, m_we=0, if_valid at cycle 2 with if_rdata=0x8C220004; stall_if high cycles 0-1.
- if_req and mem_read (d_addr=0x100) asserted same cycle -> m_addr=0x100 first, d_valid, then m_addr=if_addr, if_valid; stall_if high until fetch completes.
- mem_write, d_addr=0x200, d_wdata=0xDEADBEEF, m_ready low 3 cycles -> m_en/m_we/m_addr/m_wdata held 4 cycles, single d_valid, stall_mem high 5 cycles, d_rdata unchanged.
- Back-to-back data requests with if_req held -> accesses alternate D, I, D; no two data accesses without an intervening fetch.
- reset asserted during D_ACC wait -> next cycle m_en=0, no d_valid; with ARB_TIMEOUT_EN and m_ready stuck low, TIMEOUT=16 -> valid pulse with rdata=0 after 16 access cycles, err=1 until reset.
